// File: rtl/slab_minmax_seq.sv
// slab_minmax_seq: sequences the Ray-AABB slab reduction over one shared,
// pipelined external greater-than comparator. It finds max(tnear) and
// min(tfar) with their indices, then decides hit = far_min > near_max and
// far_min > +0. Returned comparator bits are routed by a tag pipeline that
// runs alongside cmp_vld.
module slab_minmax_seq #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned CMP_LAT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH:0]   tnear0,
   input  logic [WIDTH:0]   tnear1,
   input  logic [WIDTH:0]   tnear2,
   input  logic [WIDTH:0]   tfar0,
   input  logic [WIDTH:0]   tfar1,
   input  logic [WIDTH:0]   tfar2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH:0]   near_max,
   output logic [WIDTH:0]   far_min,
   output logic [1:0]       near_idx,
   output logic [1:0]       far_idx,
   output logic             hit,
   output logic [WIDTH:0]   cmp_a,
   output logic [WIDTH:0]   cmp_b,
   output logic             cmp_vld,
   input  logic             cmp_gt
);

   typedef enum logic [2:0] {
      IDLE, P1, W1, P2, W2, P3, W3, DONE
   } state_t;

   // Destination of a returned comparator bit.
   typedef enum logic [1:0] {
      TAG_NEAR, TAG_FAR, TAG_HIT_A, TAG_HIT_B
   } tag_t;

   state_t state, state_nxt;
   logic   second;                  // second issue cycle of a P state

   // Latched operands; tnear0/tfar0 go straight into the running winners.
   logic [WIDTH:0] n1, n2, f1, f2;
   logic [WIDTH:0] cur_n, cur_f;
   logic [1:0]     cur_ni, cur_fi;
   logic           hit_a;

   // Issue side.
   logic           issue_vld;
   logic [WIDTH:0] issue_a, issue_b;
   tag_t           issue_tag;
   logic [WIDTH:0] hold_a, hold_b;

   // Tag pipeline, aligned with the comparator latency.
   logic [CMP_LAT-1:0]      vld_pipe;
   logic [CMP_LAT-1:0][1:0] tag_pipe;
   logic                    ret_vld;
   tag_t                    ret_tag;
   logic                    phase2;
   logic                    accept;

   assign accept  = (state == IDLE) && start;
   assign ret_vld = vld_pipe[CMP_LAT-1];
   assign ret_tag = tag_t'(tag_pipe[CMP_LAT-1]);
   // Results returning while in P2/W2 belong to the index-2 candidates;
   // earlier ones (in P1/W1) to the index-1 candidates.
   assign phase2  = (state == P2) || (state == W2);

   assign busy    = (state != IDLE);
   assign done    = (state == DONE);
   assign cmp_vld = issue_vld;
   assign cmp_a   = issue_a;
   assign cmp_b   = issue_b;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         second <= 1'b0;
      end else begin
         state  <= state_nxt;
         second <= ((state == P1) || (state == P2) || (state == P3)) ? ~second : 1'b0;
      end
   end

   // Next-state logic: W states leave when the phase's second result returns.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (start) state_nxt = P1;
         P1:   if (second) state_nxt = W1;
         W1:   if (ret_vld && ret_tag == TAG_FAR) state_nxt = P2;
         P2:   if (second) state_nxt = W2;
         W2:   if (ret_vld && ret_tag == TAG_FAR) state_nxt = P3;
         P3:   if (second) state_nxt = W3;
         W3:   if (ret_vld && ret_tag == TAG_HIT_B) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand issue: near compare first, far compare second in each P state.
   always_comb begin
      issue_vld = 1'b0;
      issue_a   = hold_a;
      issue_b   = hold_b;
      issue_tag = TAG_NEAR;
      unique case (state)
         P1: begin
            issue_vld = 1'b1;
            if (!second) begin
               issue_a   = n1;
               issue_b   = cur_n;
               issue_tag = TAG_NEAR;
            end else begin
               issue_a   = cur_f;
               issue_b   = f1;
               issue_tag = TAG_FAR;
            end
         end
         P2: begin
            issue_vld = 1'b1;
            if (!second) begin
               issue_a   = n2;
               issue_b   = cur_n;
               issue_tag = TAG_NEAR;
            end else begin
               issue_a   = cur_f;
               issue_b   = f2;
               issue_tag = TAG_FAR;
            end
         end
         P3: begin
            issue_vld = 1'b1;
            issue_a   = cur_f;
            if (!second) begin
               issue_b   = cur_n;
               issue_tag = TAG_HIT_A;
            end else begin
               issue_b   = '0;
               issue_tag = TAG_HIT_B;
            end
         end
         default: ;
      endcase
   end

   // Hold the last issued operands while no pair is issued.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_a <= '0;
         hold_b <= '0;
      end else if (issue_vld) begin
         hold_a <= issue_a;
         hold_b <= issue_b;
      end
   end

   // Tag pipeline shift; cleared on reset so in-flight results are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe <= '0;
         tag_pipe <= '0;
      end else begin
         vld_pipe[0] <= issue_vld;
         tag_pipe[0] <= issue_tag;
         for (int unsigned i = 1; i < CMP_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            tag_pipe[i] <= tag_pipe[i-1];
         end
      end
   end

   // Operand latch, winner update from returned bits, and result registers.
   // "Not greater" keeps the incumbent, so ties and NaN challengers never
   // displace the lower index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n1       <= '0;
         n2       <= '0;
         f1       <= '0;
         f2       <= '0;
         cur_n    <= '0;
         cur_f    <= '0;
         cur_ni   <= '0;
         cur_fi   <= '0;
         hit_a    <= 1'b0;
         near_max <= '0;
         far_min  <= '0;
         near_idx <= '0;
         far_idx  <= '0;
         hit      <= 1'b0;
      end else if (accept) begin
         n1     <= tnear1;
         n2     <= tnear2;
         f1     <= tfar1;
         f2     <= tfar2;
         cur_n  <= tnear0;
         cur_f  <= tfar0;
         cur_ni <= 2'd0;
         cur_fi <= 2'd0;
         hit_a  <= 1'b0;
      end else if (ret_vld) begin
         unique case (ret_tag)
            TAG_NEAR: if (cmp_gt) begin
               cur_n  <= phase2 ? n2 : n1;
               cur_ni <= phase2 ? 2'd2 : 2'd1;
            end
            TAG_FAR: if (cmp_gt) begin
               cur_f  <= phase2 ? f2 : f1;
               cur_fi <= phase2 ? 2'd2 : 2'd1;
            end
            TAG_HIT_A: hit_a <= cmp_gt;
            TAG_HIT_B: begin
               near_max <= cur_n;
               far_min  <= cur_f;
               near_idx <= cur_ni;
               far_idx  <= cur_fi;
               hit      <= hit_a & cmp_gt;
            end
            default: ;
         endcase
      end
   end

endmodule
